facto_bus_master: RTL and testbench

- Bus initiator that drives the factorial core's slave register interface (sel/wr/addr/din/dout/interrupt) on behalf of an upstream requester.
- Accepts one operand per request and runs the full register sequence: program, start, wait for completion, read the 128-bit result, clear.
- Returns the result with a one-cycle done pulse.
- Sits between the system sequencer and the factorial core; it is the only master on that slave port.

---
 rtl/facto_pkg.sv | 32 +++
 rtl/facto_bus_if.sv | 54 +++++
 rtl/facto_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_facto_bus_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/facto_pkg.sv
// Shared constants and state encoding for the factorial-core bus master.
package facto_pkg;

    localparam int RESULT_W = 128;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 16;
    localparam int OFS_W    = 8;

    localparam logic [OFS_W-1:0] OFS_OPSTART  = 8'h00;
    localparam logic [OFS_W-1:0] OFS_OPCLEAR  = 8'h08;
    localparam logic [OFS_W-1:0] OFS_OPDONE   = 8'h10;
    localparam logic [OFS_W-1:0] OFS_INTREN   = 8'h18;
    localparam logic [OFS_W-1:0] OFS_OPERAND  = 8'h20;
    localparam logic [OFS_W-1:0] OFS_RESULT_H = 8'h28;
    localparam logic [OFS_W-1:0] OFS_RESULT_L = 8'h30;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_CLR0,
        ST_WR_OPND,
        ST_WR_INTR,
        ST_WR_START,
        ST_WAIT,
        ST_RD_DONE,
        ST_RD_H,
        ST_RD_L,
        ST_WR_STOP,
        ST_WR_CLR1,
        ST_FIN
    } state_e;

endpackage

// File: rtl/facto_bus_if.sv
// Registered single-cycle transaction driver for the factorial core slave port.
module facto_bus_if
    import facto_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_wr,
    input  logic [OFS_W-1:0]  i_cmd_ofs,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_m_sel,
    output logic              o_m_wr,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_dout,
    input  logic [DATA_W-1:0] i_m_din,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    logic              r_sel;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;

    // Idle cycles drive address/data to zero rather than holding stale values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel  <= 1'b0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_dout <= '0;
        end else if (i_cmd_valid) begin
            r_sel  <= 1'b1;
            r_wr   <= i_cmd_wr;
            r_addr <= BASE_ADDR + {{(ADDR_W-OFS_W){1'b0}}, i_cmd_ofs};
            r_dout <= i_cmd_wr ? i_cmd_data : '0;
        end else begin
            r_sel  <= 1'b0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_dout <= '0;
        end
    end

    assign o_m_sel    = r_sel;
    assign o_m_wr     = r_wr;
    assign o_m_addr   = r_addr;
    assign o_m_dout   = r_dout;
    assign o_rd_data  = i_m_din;
    assign o_rd_valid = r_sel & ~r_wr;

endmodule

// File: rtl/facto_bus_master.sv
// Sequences one factorial computation per request over the core's slave port.
// Build option FACTO_MASTER_IRQ_EN: wait on the core interrupt instead of polling opdone.
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | waiting for req; operand latched on acceptance
// WR_CLR0     | write opclear=0
// WR_OPND     | write operand
// WR_INTR     | write intrEn (1 in IRQ build, else 0)
// WR_START    | write opstart=1
// WAIT        | no transaction; wait for interrupt or poll gap
// RD_DONE     | read opdone (polling build only)
// RD_H        | read result_h into result[127:64]
// RD_L        | read result_l into result[63:0]
// WR_STOP     | write opstart=0
// WR_CLR1     | write opclear=1
// FIN         | done pulse, busy low
module facto_bus_master
    import facto_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                POLL_GAP  = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_req,
    input  logic [DATA_W-1:0]   i_req_operand,
    output logic                o_busy,
    output logic                o_done,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_m_sel,
    output logic                o_m_wr,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_dout,
    input  logic [DATA_W-1:0]   i_m_din,
    input  logic                i_interrupt
);

`ifdef FACTO_MASTER_IRQ_EN
    localparam logic [DATA_W-1:0] INTR_VAL = 64'd1;
`else
    localparam logic [DATA_W-1:0] INTR_VAL = 64'd0;
`endif
    localparam logic [7:0] GAP_RELOAD = 8'(POLL_GAP - 1);

    state_e              r_state;
    state_e              w_next;
    logic [DATA_W-1:0]   r_operand;
    logic                r_busy;
    logic                r_done;
    logic [RESULT_W-1:0] r_result;
    logic [7:0]          r_poll_cnt;

    logic                w_cmd_valid;
    logic                w_cmd_wr;
    logic [OFS_W-1:0]    w_cmd_ofs;
    logic [DATA_W-1:0]   w_cmd_data;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_rd_valid;

    facto_bus_if #(
        .BASE_ADDR (BASE_ADDR)
    ) u_bus_if (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_cmd_valid (w_cmd_valid),
        .i_cmd_wr    (w_cmd_wr),
        .i_cmd_ofs   (w_cmd_ofs),
        .i_cmd_data  (w_cmd_data),
        .o_m_sel     (o_m_sel),
        .o_m_wr      (o_m_wr),
        .o_m_addr    (o_m_addr),
        .o_m_dout    (o_m_dout),
        .i_m_din     (i_m_din),
        .o_rd_data   (w_rd_data),
        .o_rd_valid  (w_rd_valid)
    );

    always_comb begin
        w_next      = r_state;
        w_cmd_valid = 1'b0;
        w_cmd_wr    = 1'b0;
        w_cmd_ofs   = '0;
        w_cmd_data  = '0;

        case (r_state)
            ST_IDLE:     if (i_req) w_next = ST_WR_CLR0;
            ST_WR_CLR0:  w_next = ST_WR_OPND;
            ST_WR_OPND:  w_next = ST_WR_INTR;
            ST_WR_INTR:  w_next = ST_WR_START;
            ST_WR_START: w_next = ST_WAIT;
`ifdef FACTO_MASTER_IRQ_EN
            ST_WAIT:     if (i_interrupt) w_next = ST_RD_H;
`else
            ST_WAIT:     if (r_poll_cnt == 8'd0) w_next = ST_RD_DONE;
`endif
            ST_RD_DONE:  w_next = w_rd_data[0] ? ST_RD_H : ST_WAIT;
            ST_RD_H:     w_next = ST_RD_L;
            ST_RD_L:     w_next = ST_WR_STOP;
            ST_WR_STOP:  w_next = ST_WR_CLR1;
            ST_WR_CLR1:  w_next = ST_FIN;
            ST_FIN:      w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase

        // The bus driver registers the command, so it is issued for the state being
        // entered; the transaction then lands in that state's own cycle.
        case (w_next)
            ST_WR_CLR0: begin
                w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_ofs = OFS_OPCLEAR; w_cmd_data = 64'd0;
            end
            ST_WR_OPND: begin
                w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_ofs = OFS_OPERAND; w_cmd_data = r_operand;
            end
            ST_WR_INTR: begin
                w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_ofs = OFS_INTREN; w_cmd_data = INTR_VAL;
            end
            ST_WR_START: begin
                w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_ofs = OFS_OPSTART; w_cmd_data = 64'd1;
            end
            ST_RD_DONE: begin
                w_cmd_valid = 1'b1; w_cmd_ofs = OFS_OPDONE;
            end
            ST_RD_H: begin
                w_cmd_valid = 1'b1; w_cmd_ofs = OFS_RESULT_H;
            end
            ST_RD_L: begin
                w_cmd_valid = 1'b1; w_cmd_ofs = OFS_RESULT_L;
            end
            ST_WR_STOP: begin
                w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_ofs = OFS_OPSTART; w_cmd_data = 64'd0;
            end
            ST_WR_CLR1: begin
                w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_ofs = OFS_OPCLEAR; w_cmd_data = 64'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_operand <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE) && (w_next != ST_FIN);
            r_done  <= (w_next == ST_FIN);
            if (r_state == ST_IDLE && i_req)
                r_operand <= i_req_operand;
            if (w_rd_valid && r_state == ST_RD_H)
                r_result[RESULT_W-1:DATA_W] <= w_rd_data;
            if (w_rd_valid && r_state == ST_RD_L)
                r_result[DATA_W-1:0] <= w_rd_data;
        end
    end

    // Gap down-counter: loaded on every WAIT entry, WAIT exits at terminal count zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_poll_cnt <= 8'd0;
        end else if (r_state == ST_WR_START || r_state == ST_RD_DONE) begin
            r_poll_cnt <= GAP_RELOAD;
        end else if (r_state == ST_WAIT && r_poll_cnt != 8'd0) begin
            r_poll_cnt <= r_poll_cnt - 8'd1;
        end
    end

`ifdef FACTO_MASTER_IRQ_EN
    logic [7:0] w_unused_gap;
    assign w_unused_gap = r_poll_cnt;
`else
    logic w_unused_irq;
    assign w_unused_irq = i_interrupt;
`endif

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_facto_bus_master.sv
// Self-checking bench: behavioural factorial core plus write-order and result scoreboards.
module tb_facto_bus_master;
    import facto_pkg::*;

    localparam logic [15:0] BASE = 16'h1200;
    localparam int          GAP  = 4;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic [63:0]   req_operand;
    logic          busy;
    logic          done;
    logic [127:0]  result;
    logic          m_sel;
    logic          m_wr;
    logic [15:0]   m_addr;
    logic [63:0]   m_dout;
    logic [63:0]   m_din;
    logic          interrupt;

    int checks = 0;
    int errors = 0;

    facto_bus_master #(
        .BASE_ADDR (BASE),
        .POLL_GAP  (GAP)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_req         (req),
        .i_req_operand (req_operand),
        .o_busy        (busy),
        .o_done        (done),
        .o_result      (result),
        .o_m_sel       (m_sel),
        .o_m_wr        (m_wr),
        .o_m_addr      (m_addr),
        .o_m_dout      (m_dout),
        .i_m_din       (m_din),
        .i_interrupt   (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    // ---------------- behavioural core ----------------
    logic [63:0]  c_operand;
    logic         c_opdone;
    logic         c_intren;
    logic [127:0] c_result;
    logic         c_running;
    int           c_cnt;
    int           g_lat = 0;
    logic [15:0]  ofs;

    assign ofs       = m_addr - BASE;
    assign interrupt = c_opdone & c_intren;

    always_comb begin
        m_din = 64'h0;
        if (m_sel && !m_wr) begin
            if (ofs == 16'h10)      m_din = {63'b0, c_opdone};
            else if (ofs == 16'h28) m_din = c_result[127:64];
            else if (ofs == 16'h30) m_din = c_result[63:0];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_operand <= '0; c_opdone <= 1'b0; c_intren <= 1'b0;
            c_result <= '0; c_running <= 1'b0; c_cnt <= 0;
        end else begin
            if (c_running) begin
                if (c_cnt == 0) begin
                    c_opdone <= 1'b1; c_result <= fact(c_operand); c_running <= 1'b0;
                end else c_cnt <= c_cnt - 1;
            end
            if (m_sel && m_wr) begin
                if (ofs == 16'h00 && m_dout[0]) begin
                    if (g_lat == 0) begin c_opdone <= 1'b1; c_result <= fact(c_operand); end
                    else begin c_running <= 1'b1; c_cnt <= g_lat - 1; end
                end
                if (ofs == 16'h08 && m_dout[0]) c_opdone <= 1'b0;
                if (ofs == 16'h18) c_intren <= m_dout[0];
                if (ofs == 16'h20) c_operand <= m_dout;
            end
        end
    end

    // ---------------- bus monitor / scoreboards ----------------
    typedef struct {logic [15:0] addr; logic [63:0] data;} wr_t;
    wr_t          wr_q[$];
    logic [127:0] res_q[$];
    int           cyc = 0;
    int           last_evt = 0;
    logic         exp_rdh = 1'b0;

    always @(negedge clk) begin
        wr_t w;
        cyc <= cyc + 1;
        if (!rst_n) begin
            exp_rdh <= 1'b0;
        end else begin
            if (exp_rdh) begin
                exp_rdh <= 1'b0;
                check("exit_to_rd_h", {m_sel, m_wr, m_addr}, {1'b1, 1'b0, BASE + 16'h28});
            end
            if (m_sel && m_wr) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write", m_addr, m_dout);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 128'(m_addr), 128'(w.addr));
                    check("wr_data", 128'(m_dout), 128'(w.data));
                end
                if (ofs == 16'h00 && m_dout[0]) last_evt <= cyc;
            end
            if (m_sel && !m_wr) begin
                if (ofs == 16'h10) begin
`ifdef FACTO_MASTER_IRQ_EN
                    checks++; errors++;
                    $display("FAIL opdone_read_in_irq: got read at %h, required none", m_addr);
`else
                    check("poll_gap", 128'(cyc - last_evt), 128'(GAP + 1));
                    last_evt <= cyc;
                    if (m_din[0]) exp_rdh <= 1'b1;
`endif
                end else begin
                    check("rd_addr", 128'((ofs == 16'h28) || (ofs == 16'h30)), 128'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_front_writes(input logic [63:0] op);
`ifdef FACTO_MASTER_IRQ_EN
        logic [63:0] iv = 64'd1;
`else
        logic [63:0] iv = 64'd0;
`endif
        wr_q.push_back('{BASE + 16'h08, 64'd0});
        wr_q.push_back('{BASE + 16'h20, op});
        wr_q.push_back('{BASE + 16'h18, iv});
        wr_q.push_back('{BASE + 16'h00, 64'd1});
    endtask

    task automatic run_op(input logic [63:0] op, input int lat, input logic [127:0] exp, input bit inject);
        int n;
        bit busy_bad;
        logic [127:0] exp_r;
        g_lat = lat;
        res_q.push_back(exp);
        push_front_writes(op);
        wr_q.push_back('{BASE + 16'h00, 64'd0});
        wr_q.push_back('{BASE + 16'h08, 64'd1});
        @(negedge clk);
        req = 1'b1; req_operand = op;
        @(negedge clk);
        req = 1'b0; req_operand = {$urandom, $urandom};
        n = 1;
        busy_bad = 1'b0;
        check("busy_on_accept", 128'(busy), 128'd1);
        while (!done && n < 600) begin
            if (!busy) busy_bad = 1'b1;
            if (inject && n == 3) begin req = 1'b1; req_operand = 64'd7; end
            else req = 1'b0;
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
            res_q.delete(); wr_q.delete();
            exp_r = '0;
        end else begin
            check("busy_held", 128'(busy_bad), 128'd0);
            check("busy_low_at_done", 128'(busy), 128'd0);
            exp_r = res_q.pop_front();
            check("result", result, exp_r);
`ifdef FACTO_MASTER_IRQ_EN
            if (lat == 0) check("irq_round_trip", 128'(n), 128'd10);
`else
            if (lat == 0) check("poll_round_trip", 128'(n), 128'(10 + GAP));
`endif
        end
        @(negedge clk);
        check("done_single_cycle", 128'(done), 128'd0);
        check("result_held", result, exp_r);
        check("writes_complete", 128'(wr_q.size()), 128'd0);
    endtask

    typedef struct {logic [63:0] op; int lat; logic [127:0] exp;} vec_t;
    vec_t tbl[6];

    initial begin
        bit quiet_bad;
        tbl[0] = '{64'd5,  30, 128'h78};
        tbl[1] = '{64'd0,  0,  128'h1};
        tbl[2] = '{64'd20, 12, 128'h0000_0000_0000_0000_21C3_677C_82B4_0000};
        tbl[3] = '{64'd21, 40, {64'h2, 64'hC507_7D36_B8C4_0000}};
        tbl[4] = '{64'd10, 1,  128'h37_5F00};
        tbl[5] = '{64'd3,  7,  128'h6};

        rst_n = 1'b0; req = 1'b0; req_operand = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, done, m_sel, m_wr, m_addr, m_dout}, '0);
        check("rst_result", result, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_op(tbl[i].op, tbl[i].lat, tbl[i].exp, 1'b0);

        // Asynchronous reset while waiting on a long computation.
        g_lat = 30;
        push_front_writes(64'd8);
        @(negedge clk);
        req = 1'b1; req_operand = 64'd8;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_before_reset", 128'(busy), 128'd1);
        check("writes_before_reset", 128'(wr_q.size()), 128'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {busy, done, m_sel, m_wr, m_addr, m_dout}, '0);
        check("async_rst_result", result, '0);
        wr_q.delete(); res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'd21, 3, {64'h2, 64'hC507_7D36_B8C4_0000}, 1'b0);

        // Request pulsed mid-run must be dropped.
        run_op(64'd9, 5, 128'h5_8980, 1'b1);
        quiet_bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) quiet_bad = 1'b1;
        end
        check("no_extra_run", 128'(quiet_bad), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
